vape_multi_region: RTL

Parametrised multi-region successor to the single-region VAPE/ASAP execution monitor. It tracks `N_REG` independent executable regions (ER), each with its own output region (OR). For each region it enforces entry/exit atomicity, ER immutability, OR write protection, and IRQ/DMA exclusion, keeping a per-region EXEC flag and a sticky violation cause. It sits beside the openMSP430 core and observes `pc`, data-bus and DMA signals; the attestation logic reads its outputs.

---
 rtl/vape_pkg.sv | 24 ++
 rtl/vape_region_fsm.sv | 93 +++++++++
 rtl/vape_multi_region.sv | 81 ++++++++
 3 files changed

// File: rtl/vape_pkg.sv
// Shared encodings for the multi-region VAPE execution monitor:
// FSM states, violation cause codes and an inclusive range test.
package vape_pkg;

    typedef enum logic [1:0] {
        ST_KILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] CAUSE_NONE  = 3'd0;
    localparam logic [2:0] CAUSE_ENTRY = 3'd1;
    localparam logic [2:0] CAUSE_EXIT  = 3'd2;
    localparam logic [2:0] CAUSE_IMM   = 3'd3;
    localparam logic [2:0] CAUSE_OUT   = 3'd4;
    localparam logic [2:0] CAUSE_IRQ   = 3'd5;

    // An inverted range (lo > hi) never matches, so an empty OR is naturally inert.
    function automatic logic in_range(input logic [15:0] a, input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/vape_region_fsm.sv
// One monitored region: bound comparators, prioritised violation code,
// KILL/RUN/DONE state machine and sticky cause register.
module vape_region_fsm
    import vape_pkg::*;
(
    input  logic        clk,
    input  logic        i_puc,
    input  logic [15:0] i_pc,
    input  logic [15:0] i_prev_pc,
    input  logic        i_data_en,
    input  logic        i_data_wr,
    input  logic [15:0] i_data_addr,
    input  logic        i_dma_en,
    input  logic [15:0] i_dma_addr,
    input  logic        i_irq,
    input  logic [15:0] i_er_min,
    input  logic [15:0] i_er_max,
    input  logic [15:0] i_or_min,
    input  logic [15:0] i_or_max,
    output logic        o_exec,
    output logic [2:0]  o_cause,
    output logic        o_kill
);

    state_t     r_state;
    logic       r_exec;
    logic [2:0] r_cause;

    logic       w_valid, w_in_er, w_prev_in_er, w_cpu_wr;
    logic       w_imm, w_out, w_irq, w_entry, w_exit;
    logic [2:0] w_code;

    assign w_valid      = i_er_min <= i_er_max;
    assign w_in_er      = in_range(i_pc, i_er_min, i_er_max);
    assign w_prev_in_er = in_range(i_prev_pc, i_er_min, i_er_max);
    assign w_cpu_wr     = i_data_en & i_data_wr;

    assign w_imm   = (w_cpu_wr & in_range(i_data_addr, i_er_min, i_er_max))
                   | (i_dma_en & in_range(i_dma_addr, i_er_min, i_er_max));
    assign w_out   = (w_cpu_wr & in_range(i_data_addr, i_or_min, i_or_max) & ~w_in_er)
                   | (i_dma_en & in_range(i_dma_addr, i_or_min, i_or_max));
    assign w_irq   = (i_irq | i_dma_en) & (r_state == ST_RUN);
    assign w_entry = ~w_prev_in_er & w_in_er & (i_pc != i_er_min);
    assign w_exit  = w_prev_in_er & ~w_in_er & (i_prev_pc != i_er_max);

    always_comb begin
        w_code = CAUSE_NONE;
        if (w_imm)        w_code = CAUSE_IMM;
        else if (w_out)   w_code = CAUSE_OUT;
        else if (w_irq)   w_code = CAUSE_IRQ;
        else if (w_entry) w_code = CAUSE_ENTRY;
        else if (w_exit)  w_code = CAUSE_EXIT;
    end

    // Only a violation-driven move out of RUN/DONE counts as a KILL entry.
    assign o_kill = w_valid && (r_state != ST_KILL) && (w_code != CAUSE_NONE);

    always_ff @(posedge clk or posedge i_puc) begin
        if (i_puc) begin
            r_state <= ST_KILL;
            r_exec  <= 1'b0;
            r_cause <= CAUSE_NONE;
        end else if (!w_valid) begin
            r_state <= ST_KILL;
            r_exec  <= 1'b0;
            r_cause <= CAUSE_NONE;
        end else if (w_code != CAUSE_NONE) begin
            if (r_state != ST_KILL) begin
                r_state <= ST_KILL;
                r_exec  <= 1'b0;
                r_cause <= w_code;
            end
        end else begin
            case (r_state)
                ST_KILL: if (i_pc == i_er_min) begin
                    r_state <= ST_RUN;
                    r_exec  <= 1'b1;
                    r_cause <= CAUSE_NONE;
                end
                ST_RUN: if (!w_in_er) r_state <= ST_DONE;
                ST_DONE: if (i_pc == i_er_min) r_state <= ST_RUN;
                default: begin
                    r_state <= ST_KILL;
                    r_exec  <= 1'b0;
                end
            endcase
        end
    end

    assign o_exec  = r_exec;
    assign o_cause = r_cause;

endmodule

// File: rtl/vape_multi_region.sv
// Multi-region VAPE monitor: one FSM per region sharing a previous-PC register,
// plus a saturating counter of KILL entries across all regions.
module vape_multi_region
    import vape_pkg::*;
#(
    parameter int          N_REG         = 2,
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter int          CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 puc,
    input  logic [15:0]          pc,
    input  logic                 data_en,
    input  logic                 data_wr,
    input  logic [15:0]          data_addr,
    input  logic                 dma_en,
    input  logic [15:0]          dma_addr,
    input  logic                 irq,
    input  logic [16*N_REG-1:0]  er_min,
    input  logic [16*N_REG-1:0]  er_max,
    input  logic [16*N_REG-1:0]  or_min,
    input  logic [16*N_REG-1:0]  or_max,
    output logic [N_REG-1:0]     exec,
    output logic [3*N_REG-1:0]   cause,
    output logic [CNT_W-1:0]     viol_cnt
);

    localparam int SUM_W = CNT_W + 4;

    logic [15:0]      r_prev_pc;
    logic [CNT_W-1:0] r_viol_cnt;
    logic [N_REG-1:0] w_kill;
    logic [SUM_W-1:0] w_kill_sum, w_cnt_sum;

    generate
        for (genvar gi = 0; gi < N_REG; gi++) begin : g_region
            vape_region_fsm u_region (
                .clk         (clk),
                .i_puc       (puc),
                .i_pc        (pc),
                .i_prev_pc   (r_prev_pc),
                .i_data_en   (data_en),
                .i_data_wr   (data_wr),
                .i_data_addr (data_addr),
                .i_dma_en    (dma_en),
                .i_dma_addr  (dma_addr),
                .i_irq       (irq),
                .i_er_min    (er_min[16*gi +: 16]),
                .i_er_max    (er_max[16*gi +: 16]),
                .i_or_min    (or_min[16*gi +: 16]),
                .i_or_max    (or_max[16*gi +: 16]),
                .o_exec      (exec[gi]),
                .o_cause     (cause[3*gi +: 3]),
                .o_kill      (w_kill[gi])
            );
        end
    endgenerate

    always_comb begin
        w_kill_sum = '0;
        for (int i = 0; i < N_REG; i++) begin
            w_kill_sum = w_kill_sum + SUM_W'(w_kill[i]);
        end
    end

    assign w_cnt_sum = SUM_W'(r_viol_cnt) + w_kill_sum;

    always_ff @(posedge clk or posedge puc) begin
        if (puc) begin
            r_prev_pc  <= RESET_HANDLER;
            r_viol_cnt <= '0;
        end else begin
            r_prev_pc  <= pc;
            r_viol_cnt <= (w_cnt_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                               : w_cnt_sum[CNT_W-1:0];
        end
    end

    assign viol_cnt = r_viol_cnt;

endmodule
